// File: rtl/note_tone_gen_pkg.sv
// rtl/note_tone_gen_pkg.sv - shared synth types: tone codes, FSM states, half-period table
package note_tone_gen_pkg;

   typedef enum logic [3:0] {
      TONE_C   = 4'h0,
      TONE_CS  = 4'h1,
      TONE_D   = 4'h2,
      TONE_DS  = 4'h3,
      TONE_E   = 4'h4,
      TONE_F   = 4'h5,
      TONE_FS  = 4'h6,
      TONE_G   = 4'h7,
      TONE_GS  = 4'h8,
      TONE_A   = 4'h9,
      TONE_AS  = 4'hA,
      TONE_B   = 4'hB,
      TONE_CH  = 4'hC,
      TONE_OFF = 4'hF
   } tone_e;

   typedef enum logic [1:0] {
      S_SILENT,
      S_PLAY,
      S_RELEASE
   } state_e;

   localparam int NUM_NOTES = 13;

   // Half-period in 10 MHz clk cycles, indexed by tone code C..high C
   localparam logic [14:0] HP_TABLE [NUM_NOTES] = '{
      15'd19111, 15'd18039, 15'd17026, 15'd16071, 15'd15169, 15'd14317, 15'd13514,
      15'd12755, 15'd12039, 15'd11364, 15'd10726, 15'd10124, 15'd9556
   };

   function automatic logic is_note(input logic [3:0] code);
      return code <= TONE_CH;
   endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// rtl/note_tone_gen_if.sv - control inputs and audio/status outputs of the tone generator
interface note_tone_gen_if;
   logic       en;
   logic       clkdiv;
   logic [3:0] note_in;
   logic       wave_out;
   logic       active;
   logic [3:0] cur_note;

   modport master (output en, clkdiv, note_in, input wave_out, active, cur_note);
   modport slave  (input en, clkdiv, note_in, output wave_out, active, cur_note);
endinterface

// File: rtl/note_period_rom.sv
// rtl/note_period_rom.sv - combinational tone code to half-period lookup; 0 for OFF/invalid
module note_period_rom
   import note_tone_gen_pkg::*;
(
   input  logic [3:0]  code,
   output logic [14:0] hp
);

   always_comb begin
      hp = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (code == 4'(i)) hp = HP_TABLE[i];
      end
   end

endmodule

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - square-wave note generator with SILENT/PLAY/RELEASE envelope FSM
module note_tone_gen
   import note_tone_gen_pkg::*;
#(
   parameter int REL_TICKS = 4
)
(
   input  logic           clk,
   input  logic           rst,
   note_tone_gen_if.slave bus
);

   localparam int REL_W = (REL_TICKS < 2) ? 1 : $clog2(REL_TICKS + 1);

   state_e             state;
   logic               wave;
   logic               act;
   logic [3:0]         cur;
   logic [14:0]        cnt;
   logic [REL_W-1:0]   rel;

   logic [14:0]        hp_new;
   logic [14:0]        hp_cur;
   logic               note_valid;
   logic [14:0]        run_cnt;
   logic               run_wave;

   note_period_rom u_rom_new (.code(bus.note_in), .hp(hp_new));
   note_period_rom u_rom_cur (.code(cur),         .hp(hp_cur));

   assign note_valid = is_note(bus.note_in);

   // Free-running next values of the tone counter for the note already sounding
   always_comb begin
      run_cnt  = cnt - 15'd1;
      run_wave = wave;
      if (cnt == 15'd0) begin
         run_cnt  = hp_cur - 15'd1;
         run_wave = ~wave;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_SILENT;
         wave  <= 1'b0;
         act   <= 1'b0;
         cur   <= TONE_OFF;
         cnt   <= '0;
         rel   <= '0;
      end else if (!bus.en) begin
         state <= S_SILENT;
         wave  <= 1'b0;
         act   <= 1'b0;
         cur   <= TONE_OFF;
         cnt   <= '0;
         rel   <= '0;
      end else begin
         case (state)
            S_SILENT: begin
               if (note_valid) begin
                  state <= S_PLAY;
                  act   <= 1'b1;
                  cur   <= bus.note_in;
                  cnt   <= hp_new - 15'd1;
                  wave  <= 1'b0;
               end
            end
            S_PLAY: begin
               if (note_valid && bus.note_in != cur) begin
                  cur  <= bus.note_in;
                  cnt  <= hp_new - 15'd1;
                  wave <= 1'b0;
               end else if (note_valid) begin
                  cnt  <= run_cnt;
                  wave <= run_wave;
               end else if (REL_TICKS == 0) begin
                  state <= S_SILENT;
                  act   <= 1'b0;
                  cur   <= TONE_OFF;
                  cnt   <= '0;
                  wave  <= 1'b0;
               end else begin
                  state <= S_RELEASE;
                  rel   <= REL_W'(REL_TICKS);
                  cnt   <= run_cnt;
                  wave  <= run_wave;
               end
            end
            S_RELEASE: begin
               // A new note always wins over a simultaneous final release tick
               if (note_valid) begin
                  state <= S_PLAY;
                  cur   <= bus.note_in;
                  cnt   <= hp_new - 15'd1;
                  wave  <= 1'b0;
                  rel   <= '0;
               end else if (bus.clkdiv && rel == REL_W'(1)) begin
                  state <= S_SILENT;
                  act   <= 1'b0;
                  cur   <= TONE_OFF;
                  cnt   <= '0;
                  rel   <= '0;
                  wave  <= 1'b0;
               end else begin
                  cnt  <= run_cnt;
                  wave <= run_wave;
                  if (bus.clkdiv) rel <= rel - REL_W'(1);
               end
            end
            default: begin
               state <= S_SILENT;
               act   <= 1'b0;
               cur   <= TONE_OFF;
               cnt   <= '0;
               rel   <= '0;
               wave  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wave_out = wave;
   assign bus.active   = act;
   assign bus.cur_note = cur;

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - randomized and directed bench for note_tone_gen against a time-based tone model
module tb_note_tone_gen;

   localparam int REL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #50 clk = ~clk;

   note_tone_gen_if bus();
   note_tone_gen #(.REL_TICKS(REL)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;
   bit chk_on   = 1'b0;

   // Model: mode 0 silent, 1 play, 2 release; m_t counts clks since the tone (re)started
   int m_mode = 0;
   int m_note = 15;
   int m_t    = 0;
   int m_rel  = 0;

   function automatic int hp_of(input int n);
      int tbl [13] = '{19111, 18039, 17026, 16071, 15169, 14317, 13514,
                       12755, 12039, 11364, 10726, 10124, 9556};
      if (n >= 0 && n <= 12) return tbl[n];
      return 0;
   endfunction

   function automatic int exp_wave();
      if (m_mode == 0) return 0;
      return (m_t / hp_of(m_note)) % 2;
   endfunction

   function automatic int exp_active();
      return (m_mode != 0) ? 1 : 0;
   endfunction

   function automatic int exp_cur();
      return (m_mode == 0) ? 15 : m_note;
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_silence();
      m_mode = 0; m_note = 15; m_t = 0; m_rel = 0;
   endtask

   task automatic model_start(input int n);
      m_mode = 1; m_note = n; m_t = 0;
   endtask

   task automatic model_step(input bit en, input bit tick, input int n);
      bit valid;
      valid = (n <= 12);
      if (!en) model_silence();
      else if (m_mode == 0) begin
         if (valid) model_start(n);
      end else if (m_mode == 1) begin
         if (valid && n != m_note) model_start(n);
         else if (valid) m_t++;
         else if (REL == 0) model_silence();
         else begin m_t++; m_mode = 2; m_rel = REL; end
      end else begin
         if (valid) model_start(n);
         else if (tick && m_rel == 1) model_silence();
         else begin
            m_t++;
            if (tick) m_rel--;
         end
      end
   endtask

   // One clk cycle: drive after the falling edge, step the model at the rising edge, return 1 time unit later
   task automatic cycle(input bit en, input bit tick, input int n);
      @(negedge clk);
      #1;
      bus.en      = en;
      bus.clkdiv  = tick;
      bus.note_in = 4'(n);
      @(posedge clk);
      model_step(en, tick, n);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         check("wave_out", int'(bus.wave_out), exp_wave());
         check("active",   int'(bus.active),   exp_active());
         check("cur_note", int'(bus.cur_note), exp_cur());
      end
   end

   initial begin
      int ticks;
      int n;
      bit en_r, tick_r;

      bus.en = 1'b0; bus.clkdiv = 1'b0; bus.note_in = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_wave", int'(bus.wave_out), 0);
      check("reset_active", int'(bus.active), 0);
      check("reset_cur", int'(bus.cur_note), 15);
      @(negedge clk);
      rst = 1'b0;
      model_silence();
      chk_on = 1'b1;

      // A held: first rise HP cycles after entering PLAY, then toggles every HP
      cycle(1, 0, 9);
      check("a_enter_active", int'(bus.active), 1);
      check("a_enter_cur", int'(bus.cur_note), 9);
      for (int k = 1; k <= 22728; k++) begin
         cycle(1, 0, 9);
         if (k == 11363) check("a_before_rise", int'(bus.wave_out), 0);
         if (k == 11364) check("a_rise", int'(bus.wave_out), 1);
         if (k == 22727) check("a_before_fall", int'(bus.wave_out), 1);
         if (k == 22728) check("a_fall", int'(bus.wave_out), 0);
      end

      // C then high C mid-period
      cycle(1, 0, 0);
      for (int k = 1; k <= 19211; k++) cycle(1, 0, 0);
      check("c_high_phase", int'(bus.wave_out), 1);
      cycle(1, 0, 12);
      check("ch_restart_wave", int'(bus.wave_out), 0);
      check("ch_cur", int'(bus.cur_note), 12);
      for (int k = 1; k <= 9556; k++) begin
         cycle(1, 0, 12);
         if (k == 9555) check("ch_before_rise", int'(bus.wave_out), 0);
         if (k == 9556) check("ch_rise", int'(bus.wave_out), 1);
      end

      // Release with a tick every 100 cycles
      cycle(1, 0, 9);
      repeat (50) cycle(1, 0, 9);
      ticks = 0;
      for (int k = 0; k < 400; k++) begin
         cycle(1, (k % 100) == 99, 15);
         if ((k % 100) == 99) begin
            ticks++;
            if (ticks == 3) check("rel_tick3_active", int'(bus.active), 1);
            if (ticks == 4) begin
               check("rel_done_active", int'(bus.active), 0);
               check("rel_done_cur", int'(bus.cur_note), 15);
               check("rel_done_wave", int'(bus.wave_out), 0);
            end
         end
      end

      // Note and final release tick together: note wins
      cycle(1, 0, 9);
      repeat (10) cycle(1, 0, 9);
      for (int k = 0; k < 3; k++) begin
         repeat (5) cycle(1, 0, 15);
         cycle(1, 1, 15);
      end
      check("race_pre_active", int'(bus.active), 1);
      cycle(1, 1, 4);
      check("race_active", int'(bus.active), 1);
      check("race_cur", int'(bus.cur_note), 4);
      check("race_wave", int'(bus.wave_out), 0);
      repeat (200) cycle(1, 0, 4);

      // Invalid code from SILENT, then en drop during PLAY
      cycle(0, 0, 4);
      repeat (5) cycle(1, 0, 13);
      check("code_d_active", int'(bus.active), 0);
      check("code_d_cur", int'(bus.cur_note), 15);
      cycle(1, 0, 2);
      repeat (20) cycle(1, 0, 2);
      cycle(0, 0, 2);
      check("en_drop_active", int'(bus.active), 0);
      check("en_drop_cur", int'(bus.cur_note), 15);

      // Randomized traffic
      n = 3;
      for (int k = 0; k < 6000; k++) begin
         if ($urandom_range(0, 99) < 5) n = int'($urandom_range(0, 15));
         en_r   = ($urandom_range(0, 199) != 0);
         tick_r = ($urandom_range(0, 9) == 0);
         cycle(en_r, tick_r, n);
      end

      // Asynchronous reset between edges during PLAY
      cycle(1, 0, 5);
      repeat (100) cycle(1, 0, 5);
      check("pre_arst_active", int'(bus.active), 1);
      #20;
      rst = 1'b1;
      #1;
      check("arst_active", int'(bus.active), 0);
      check("arst_cur", int'(bus.cur_note), 15);
      check("arst_wave", int'(bus.wave_out), 0);
      model_silence();
      #10;
      rst = 1'b0;
      cycle(1, 0, 7);
      check("post_arst_active", int'(bus.active), 1);
      check("post_arst_cur", int'(bus.cur_note), 7);
      repeat (20) cycle(1, 0, 7);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/note_tone_gen.md
NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 SHALL have parameter REL_TICKS, default 4: number of clkdiv ticks a tone sustains after the note goes OFF.
REQ-002 SHALL have port clk, input, 1 bit: system clock at 10 MHz; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: synchronous enable; 0 forces silence.
REQ-005 SHALL have port clkdiv, input, 1 bit: one-clk-wide tick pulse for release timing.
REQ-006 SHALL have port note_in, input, 4 bits: note code from the sound series player; 0x0..0xC = C..high C; 0xF = OFF.
REQ-007 SHALL have port wave_out, output, 1 bit: square-wave audio.
REQ-008 SHALL have port active, output, 1 bit: high when state is not SILENT.
REQ-009 SHALL have port cur_note, output, 4 bits: note currently sounding; 0xF when SILENT.

Function
REQ-010 SHALL treat codes 0xD and 0xE as OFF.
REQ-011 SHALL use these half-period counts HP, in clk cycles, for C..Ch: 19111, 18039, 17026, 16071, 15169, 14317, 13514, 12755, 12039, 11364, 10726, 10124, 9556.
REQ-012 SHALL use a 15-bit down-counter; while PLAY or RELEASE it decrements each clk, and at 0 it toggles wave_out and reloads HP-1 (wave period = 2*HP cycles).
REQ-013 SHALL implement the FSM states SILENT, PLAY and RELEASE.
REQ-014 In SILENT, a valid note_in SHALL cause: next state PLAY, cur_note <= note_in, counter <= HP-1, wave_out <= 0.
REQ-015 In PLAY, note_in equal to cur_note SHALL leave the tone running undisturbed.
REQ-016 In PLAY, a different valid note SHALL cause: stay PLAY, cur_note update, counter reload with the new HP-1, wave_out <= 0.
REQ-017 In PLAY, OFF SHALL cause: next state RELEASE, release counter <= REL_TICKS, tone keeps running on the last note.
REQ-018 In PLAY, OFF with REL_TICKS=0 SHALL cause: next state SILENT directly.
REQ-019 In RELEASE, each clkdiv SHALL decrement the release counter.
REQ-020 In RELEASE, clkdiv while the release counter is 1 SHALL cause: next state SILENT, wave_out <= 0, cur_note <= 0xF.
REQ-021 In RELEASE, a valid note SHALL cause PLAY with reload as in REQ-014, including when clkdiv is asserted in the same cycle (note wins).
REQ-022 en=0 SHALL override all of REQ-014..REQ-021: next state SILENT, wave_out 0, cur_note 0xF, counters held at 0.
REQ-023 Latency: a note_in change sampled at edge N SHALL be reflected in state and outputs after edge N; wave_out first toggles HP cycles later.
REQ-024 In SILENT, wave_out SHALL be 0 and the counter SHALL NOT run.
REQ-025 note_in changes faster than HP SHALL each restart the tone with no glitch pulse shorter than one clk.

Reset
REQ-026 rst=1 SHALL asynchronously force: state SILENT, wave_out 0, active 0, cur_note 0xF, both counters 0.
REQ-027 Reset asserted mid-tone SHALL abort the tone immediately.
REQ-028 After reset deasserts, operation SHALL resume at the first rising edge.

Structure
REQ-029 The tone enum (OFF=0xF, C..Ch) and the HP table constant SHALL live in the shared synth package, shared with the sound series player.
REQ-030 The HP lookup SHALL be one natural sub-module, note_period_rom: combinational, 4-bit code in, 15-bit HP out, 0 for OFF or invalid codes.
REQ-031 The FSM and counters SHALL be in note_tone_gen.

Verification
REQ-032 rst pulse, then en=1, note_in=0x9 held -> wave_out rises 11364 cycles after entering PLAY, then toggles every 11364 cycles; active=1, cur_note=0x9.
REQ-033 note_in 0x0 -> 0xC mid-period -> wave_out=0 next cycle and next toggle 9556 cycles later; cur_note=0xC.
REQ-034 PLAY A then note_in=0xF, REL_TICKS=4, clkdiv every 100 cycles -> tone continues through 3 ticks; SILENT after 4th tick; wave_out=0, active=0, cur_note=0xF.
REQ-035 In RELEASE, note_in=0x4 and clkdiv with release counter=1 in the same cycle -> PLAY with E (HP 15169), not SILENT.
REQ-036 note_in=0xD from SILENT -> stays SILENT; en dropped during PLAY -> SILENT next cycle.
REQ-037 rst asserted asynchronously between clk edges during PLAY -> outputs reset without waiting for an edge.
